// File: rtl/core_cluster_pkg.sv
// -----------------------------------------------------------------------------
// core_cluster_pkg
// Shared definitions for the core cluster reducer:
//   - opcode_e : instruction opcodes decoded by every standard lane
//   - state_e  : control FSM states of the reducer
//   - LFSR seed, tap positions and a one-step advance helper for the optional
//     probabilistic lane (enabled by the PROB_LANE_EN macro in the top level)
// -----------------------------------------------------------------------------
package core_cluster_pkg;

    localparam int OPC_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_MUL = 4'h3
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_REDUCE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int          LFSR_W     = 16;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam int          LFSR_TAP_A = 16;
    localparam int          LFSR_TAP_B = 14;
    localparam int          LFSR_TAP_C = 13;
    localparam int          LFSR_TAP_D = 11;

    // Right-shifting Fibonacci form: tap n reads state bit (LFSR_W - n).
    localparam logic [15:0] LFSR_TAP_MASK = (16'd1 << (LFSR_W - LFSR_TAP_A))
                                          | (16'd1 << (LFSR_W - LFSR_TAP_B))
                                          | (16'd1 << (LFSR_W - LFSR_TAP_C))
                                          | (16'd1 << (LFSR_W - LFSR_TAP_D));

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = ^(s & LFSR_TAP_MASK);
        return {fb, s[15:1]};
    endfunction

endpackage

// File: rtl/core_lane.sv
// -----------------------------------------------------------------------------
// core_lane
// One reduction lane. While load is high (reducer in EXEC) it evaluates the
// registered instruction for its own lane index and captures the result in
// lane_out. A lane built with IS_PROB=1 ignores the opcode and captures the
// single probabilistic bit instead.
//
// Parameters:
//   DATA_W   - instruction / result width
//   LANE_IDX - lane index i used by ADD (+i), SUB (-i), MUL (*(i+1))
//   IS_PROB  - 1: lane captures prob_bit zero-extended, 0: opcode lane
// Ports:
//   clk, rst  - clock, synchronous active-high reset (clears lane_out)
//   load      - capture enable
//   instr     - instruction: opcode [DATA_W-1:DATA_W-4], operand below
//   prob_bit  - probabilistic bit (read only when IS_PROB=1)
//   lane_out  - registered lane result
// -----------------------------------------------------------------------------
module core_lane
    import core_cluster_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int LANE_IDX = 0,
    parameter bit IS_PROB  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] instr,
    input  logic              prob_bit,
    output logic [DATA_W-1:0] lane_out
);

    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] idx;
    logic [DATA_W-1:0] idx_plus1;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] lane_d;
    logic [DATA_W-1:0] lane_q;
    opcode_e           opc;

    // Each lane variant reads only some of its inputs; this tie-off keeps the
    // others visibly consumed.
    logic              unused_inputs;
    assign unused_inputs = ^{prob_bit, instr};

    assign opc       = opcode_e'(instr[DATA_W-1 -: OPC_W]);
    assign operand   = {{OPC_W{1'b0}}, instr[DATA_W-OPC_W-1:0]};
    assign idx       = DATA_W'(LANE_IDX);
    assign idx_plus1 = DATA_W'(LANE_IDX + 1);

    always_comb begin
        result = '0;
        case (opc)
            OP_ADD:  result = operand + idx;
            OP_SUB:  result = operand - idx;
            OP_MUL:  result = operand * idx_plus1;
            default: result = '0;   // NOP and undefined opcodes
        endcase
    end

    always_comb begin
        lane_d = lane_q;
        if (load) begin
            lane_d = IS_PROB ? {{(DATA_W-1){1'b0}}, prob_bit} : result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= '0;
        end else begin
            lane_q <= lane_d;
        end
    end

    assign lane_out = lane_q;

endmodule

// File: rtl/core_cluster_reducer.sv
// -----------------------------------------------------------------------------
// core_cluster_reducer
// Accepts one instruction, fans it out to L lanes that each compute a
// lane-specific result (EXEC), then sums the lanes one per cycle (REDUCE) into
// a DATA_W accumulator with a sticky carry-out flag, and presents the sum with
// a valid/ready handshake (DONE).
//
// Optional feature, macro PROB_LANE_EN: adds an extra lane (L = NUM_CORES+1)
// whose value is bit 0 of a 16-bit Fibonacci LFSR advanced once per accepted
// instruction. Without the macro, L = NUM_CORES and no LFSR exists.
//
// Parameters:
//   NUM_CORES - number of standard lanes (2..16)
//   DATA_W    - instruction / result width (8..64)
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   in_valid     - in_instr valid
//   in_ready     - instruction accepted (high only in IDLE)
//   in_instr     - opcode [DATA_W-1:DATA_W-4], operand [DATA_W-5:0]
//   out_valid    - result valid (high only in DONE)
//   out_ready    - consumer accepts the result
//   out_result   - lane sum modulo 2^DATA_W
//   out_overflow - sticky unsigned carry-out of the reduction
//   busy         - state is not IDLE
// -----------------------------------------------------------------------------
module core_cluster_reducer
    import core_cluster_pkg::*;
#(
    parameter int NUM_CORES = 8,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_overflow,
    output logic              busy
);

`ifdef PROB_LANE_EN
    localparam int L = NUM_CORES + 1;
`else
    localparam int L = NUM_CORES;
`endif
    localparam int CNT_W = $clog2(L);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] acc_q,   acc_d;
    logic              ovf_q,   ovf_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic [DATA_W-1:0] lane_out [L];
    logic [DATA_W-1:0] lane_sel;
    logic [DATA_W:0]   sum_full;
    logic              accept;
    logic              lane_load;
    logic              prob_bit;

    assign accept    = (state_q == ST_IDLE) && in_valid;
    assign lane_load = (state_q == ST_EXEC);

`ifdef PROB_LANE_EN
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    // Advance at acceptance so the EXEC capture sees the post-advance bit.
    always_comb begin
        lfsr_d = lfsr_q;
        if (accept) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign prob_bit = lfsr_q[0];
`else
    assign prob_bit = 1'b0;
`endif

    // Lane array: standard lanes 0..NUM_CORES-1, optional probabilistic lane.
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_lane
        core_lane #(
            .DATA_W   (DATA_W),
            .LANE_IDX (i),
            .IS_PROB  (1'b0)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .load     (lane_load),
            .instr    (instr_q),
            .prob_bit (1'b0),
            .lane_out (lane_out[i])
        );
    end

`ifdef PROB_LANE_EN
    core_lane #(
        .DATA_W   (DATA_W),
        .LANE_IDX (NUM_CORES),
        .IS_PROB  (1'b1)
    ) u_prob_lane (
        .clk      (clk),
        .rst      (rst),
        .load     (lane_load),
        .instr    (instr_q),
        .prob_bit (prob_bit),
        .lane_out (lane_out[NUM_CORES])
    );
`else
    logic unused_prob;
    assign unused_prob = prob_bit;
`endif

    assign lane_sel = lane_out[cnt_q];
    assign sum_full = {1'b0, acc_q} + {1'b0, lane_sel};

    // Control / next-state logic.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    instr_d = in_instr;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                acc_d   = '0;
                ovf_d   = 1'b0;
                cnt_d   = '0;
                state_d = ST_REDUCE;
            end
            ST_REDUCE: begin
                acc_d = sum_full[DATA_W-1:0];
                ovf_d = ovf_q | sum_full[DATA_W];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(L - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // The accumulator is only touched in EXEC/REDUCE, so it already holds the
    // final sum throughout DONE.
    assign in_ready     = (state_q == ST_IDLE);
    assign out_valid    = (state_q == ST_DONE);
    assign out_result   = acc_q;
    assign out_overflow = ovf_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_core_cluster_reducer.sv
// -----------------------------------------------------------------------------
// Testbench for core_cluster_reducer (NUM_CORES=8, DATA_W=32). Builds with or
// without PROB_LANE_EN; expectations come from a sum-of-lanes reference model.
// -----------------------------------------------------------------------------
module tb_core_cluster_reducer;

    localparam int NUM_CORES = 8;
    localparam int DATA_W    = 32;
`ifdef PROB_LANE_EN
    localparam int L = NUM_CORES + 1;
`else
    localparam int L = NUM_CORES;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] lfsr_m;

    core_cluster_reducer #(
        .NUM_CORES (NUM_CORES),
        .DATA_W    (DATA_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, shifting right.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[16-16] ^ s[16-14] ^ s[16-13] ^ s[16-11];
        return {fb, s[15:1]};
    endfunction

    // Sum of all lane values with plain integer arithmetic modulo 2^32.
    function automatic void ref_model(input logic [31:0] instr, input bit pbit,
                                      output logic [31:0] res, output bit ovf);
        longint unsigned m;
        longint unsigned op;
        longint unsigned v;
        longint unsigned acc;
        longint unsigned li;
        logic [3:0]      opc;
        m   = 64'h1_0000_0000;
        op  = {36'd0, instr[27:0]};
        opc = instr[31:28];
        acc = 0;
        ovf = 1'b0;
        for (int i = 0; i < L; i++) begin
            li = longint'(i);
            if (i == NUM_CORES) begin
                v = {63'd0, pbit};
            end else begin
                case (opc)
                    4'h1:    v = (op + li) % m;
                    4'h2:    v = (op + m - li) % m;
                    4'h3:    v = (op * (li + 1)) % m;
                    default: v = 0;
                endcase
            end
            acc = acc + v;
            if (acc >= m) begin
                acc = acc - m;
                ovf = 1'b1;
            end
        end
        res = acc[31:0];
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_instr  = '0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        lfsr_m = 16'hACE1;
    endtask

    // Present instr until accepted, then count cycles until out_valid.
    // lat = cycles from the accepting cycle to the out_valid cycle, -1 on timeout.
    task automatic issue(input logic [31:0] instr, output int lat, output bit pbit);
        int k;
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = instr;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        lfsr_m = lfsr_step(lfsr_m);
        pbit   = lfsr_m[0];
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result: got %h expected 00000000", out_result); end
        checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL reset_out_overflow: got %b expected 0", out_overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_directed();
        logic [31:0] d_instr [3];
        logic [31:0] d_res   [3];
        bit          d_ovf   [3];
        logic [31:0] exp_r;
        int          lat;
        bit          pb;
        d_instr = '{32'h1000_0005, 32'h3000_0003, 32'h2000_0000};
        d_res   = '{32'h0000_0044, 32'h0000_006C, 32'hFFFF_FFE4};
        d_ovf   = '{1'b0, 1'b0, 1'b1};
        for (int t = 0; t < 3; t++) begin
            issue(d_instr[t], lat, pb);
            exp_r = d_res[t];
`ifdef PROB_LANE_EN
            exp_r = exp_r + {31'd0, pb};
`endif
            checks++; if (lat !== L + 2) begin errors++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", t, lat, L + 2); end
            checks++; if (out_result !== exp_r) begin errors++; $display("FAIL directed_result[%0d]: got %h expected %h", t, out_result, exp_r); end
            checks++; if (out_overflow !== d_ovf[t]) begin errors++; $display("FAIL directed_overflow[%0d]: got %b expected %b", t, out_overflow, d_ovf[t]); end
            drain();
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL directed_release[%0d]: got out_valid=%b in_ready=%b expected 0/1", t, out_valid, in_ready); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_r;
        bit          exp_o;
        int          lat;
        bit          pb;
        issue(32'h1000_0005, lat, pb);
        ref_model(32'h1000_0005, pb, exp_r, exp_o);
        in_valid = 1'b1;
        in_instr = 32'h3000_0003;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b expected 1", c, out_valid); end
            checks++; if (out_result !== exp_r) begin errors++; $display("FAIL hold_result[%0d]: got %h expected %h", c, out_result, exp_r); end
            checks++; if (out_overflow !== exp_o) begin errors++; $display("FAIL hold_overflow[%0d]: got %b expected %b", c, out_overflow, exp_o); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d]: got %b expected 0", c, in_ready); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_idle: got out_valid=%b in_ready=%b busy=%b expected 0/1/0", out_valid, in_ready, busy);
        end
        // in_valid is still high, so this IDLE cycle accepts the waiting instruction.
        lfsr_m = lfsr_step(lfsr_m);
        pb = lfsr_m[0];
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept: got busy=%b in_ready=%b expected 1/0", busy, in_ready); end
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        ref_model(32'h3000_0003, pb, exp_r, exp_o);
        checks++; if (lat !== L + 2) begin errors++; $display("FAIL bp_latency: got %0d expected %0d", lat, L + 2); end
        checks++; if (out_result !== exp_r) begin errors++; $display("FAIL bp_result: got %h expected %h", out_result, exp_r); end
        drain();
    endtask

    task automatic test_early_out_ready();
        logic [31:0] exp_r;
        bit          exp_o;
        int          lat;
        bit          pb;
        out_ready = 1'b1;
        issue(32'h1000_0005, lat, pb);
        ref_model(32'h1000_0005, pb, exp_r, exp_o);
        checks++; if (lat !== L + 2) begin errors++; $display("FAIL early_ready_latency: got %0d expected %0d", lat, L + 2); end
        checks++; if (out_result !== exp_r) begin errors++; $display("FAIL early_ready_result: got %h expected %h", out_result, exp_r); end
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL early_ready_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_r;
        bit          exp_o;
        int          lat;
        bit          pb;
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = 32'h3000_0003;
        repeat (4) @(negedge clk);   // EXEC, then into REDUCE
        rst       = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        lfsr_m    = 16'hACE1;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset_state: got in_ready=%b busy=%b out_valid=%b expected 1/0/0", in_ready, busy, out_valid);
        end
        checks++; if (out_result !== 32'h0 || out_overflow !== 1'b0) begin
            errors++; $display("FAIL mid_reset_outputs: got result=%h ovf=%b expected 00000000/0", out_result, out_overflow);
        end
        issue(32'h1000_0005, lat, pb);
        ref_model(32'h1000_0005, pb, exp_r, exp_o);
        checks++; if (lat !== L + 2) begin errors++; $display("FAIL mid_reset_latency: got %0d expected %0d", lat, L + 2); end
        checks++; if (out_result !== exp_r || out_overflow !== exp_o) begin
            errors++; $display("FAIL mid_reset_result: got %h/%b expected %h/%b", out_result, out_overflow, exp_r, exp_o);
        end
        drain();
    endtask

    task automatic test_random();
        logic [31:0] instr;
        logic [31:0] exp_r;
        bit          exp_o;
        int          lat;
        int          hold;
        bit          pb;
        for (int n = 0; n < 60; n++) begin
            instr[31:28] = (n % 5 == 4) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            instr[27:0]  = (n % 3 == 0) ? 28'($urandom_range(32'h0FFF_FF00, 32'h0FFF_FFFF))
                                        : 28'($urandom);
            issue(instr, lat, pb);
            ref_model(instr, pb, exp_r, exp_o);
            checks++; if (lat !== L + 2) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, lat, L + 2); end
            checks++; if (out_result !== exp_r) begin errors++; $display("FAIL rand_result[%0d] instr=%h: got %h expected %h", n, instr, out_result, exp_r); end
            checks++; if (out_overflow !== exp_o) begin errors++; $display("FAIL rand_overflow[%0d] instr=%h: got %b expected %b", n, instr, out_overflow, exp_o); end
            hold = $urandom_range(0, 3);
            repeat (hold) @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_result !== exp_r) begin
                errors++; $display("FAIL rand_stable[%0d]: got valid=%b result=%h expected 1/%h", n, out_valid, out_result, exp_r);
            end
            drain();
        end
    endtask

`ifdef PROB_LANE_EN
    task automatic test_prob_lane();
        logic [31:0] exp_r;
        int          lat;
        bit          pb;
        for (int n = 0; n < 100; n++) begin
            issue(32'h1000_0005, lat, pb);
            exp_r = 32'd68 + {31'd0, pb};
            checks++; if (lat !== NUM_CORES + 3) begin errors++; $display("FAIL prob_latency[%0d]: got %0d expected %0d", n, lat, NUM_CORES + 3); end
            checks++; if (out_result !== exp_r) begin errors++; $display("FAIL prob_result[%0d]: got %h expected %h", n, out_result, exp_r); end
            drain();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_early_out_ready();
        test_reset_mid();
        test_random();
`ifdef PROB_LANE_EN
        test_prob_lane();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_cluster_reducer.md
CORE_CLUSTER_REDUCER -- requirements
Module: core_cluster_reducer

Interface
REQ-001 SHALL have parameter NUM_CORES, default 8: number of standard lanes, legal range 2..16.
REQ-002 SHALL have parameter DATA_W, default 32: instruction and result width, legal range 8..64.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: in_instr is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts an instruction; high only in IDLE.
REQ-008 SHALL have port in_instr, input, DATA_W bits: opcode in bits [DATA_W-1:DATA_W-4], operand in bits [DATA_W-5:0].
REQ-009 SHALL have port out_valid, output, 1 bit: out_result and out_overflow are valid; high only in DONE.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port out_result, output, DATA_W bits: reduced sum modulo 2^DATA_W.
REQ-012 SHALL have port out_overflow, output, 1 bit: sticky unsigned carry-out seen during the reduction.
REQ-013 SHALL have port busy, output, 1 bit: state is not IDLE.

Function
REQ-014 SHALL implement an FSM with states IDLE, EXEC, REDUCE and DONE.
REQ-015 SHALL register in_instr and move to EXEC when in_valid and in_ready are both high in IDLE; SHALL ignore in_valid in every other state.
REQ-016 SHALL have each lane i register lane_out[i] in EXEC, with operand zero-extended to DATA_W, as follows: NOP (4'h0) gives 0; ADD (4'h1) gives operand+i; SUB (4'h2) gives operand-i; MUL (4'h3) gives operand*(i+1); every other opcode gives 0; all results truncated to DATA_W.
REQ-017 SHALL go from EXEC to REDUCE in one cycle, clearing the accumulator, the overflow flag and the lane counter.
REQ-018 SHALL add one lane per cycle in REDUCE, in order lane 0 first, with acc <= acc + lane_out[cnt]; SHALL OR the carry-out into the overflow flag.
REQ-019 SHALL go to DONE after the last lane is added.
REQ-020 SHALL, for an instruction accepted at cycle T, assert out_valid at cycle T+2+L, where L is the lane count.
REQ-021 SHALL hold out_valid, out_result and out_overflow stable in DONE until out_ready is high.
REQ-022 SHALL return to IDLE the cycle after out_valid and out_ready are both high.
REQ-023 SHALL keep in_ready low in DONE, so back-to-back instructions see one IDLE bubble.
REQ-024 SHALL ignore out_ready outside DONE.

Reset
REQ-025 SHALL, on rst high at a clock edge, set state to IDLE, acc to 0, overflow flag to 0, lane counter to 0, and all lane_out and the instruction register to 0.
REQ-026 SHALL give reset output values in_ready=1, out_valid=0, out_result=0, out_overflow=0 and busy=0.
REQ-027 SHALL, on reset mid-operation in any state, discard the in-flight instruction with no output handshake.
REQ-028 SHALL let rst override in_valid and out_ready in the same cycle.

Configuration
REQ-029 SHALL, with macro PROB_LANE_EN defined, add lane NUM_CORES (L = NUM_CORES+1): a 16-bit Fibonacci LFSR with taps 16,14,13,11, reset seed 16'hACE1, advanced once per accepted instruction; its lane_out is {DATA_W-1 zeros, lfsr[0] after the advance}, whatever the opcode.
REQ-030 SHALL, without PROB_LANE_EN, have no LFSR and use L = NUM_CORES.

Structure
REQ-031 SHALL put the opcode enum (NOP, ADD, SUB, MUL), the FSM state enum, the LFSR seed and the tap constants in shared package core_cluster_pkg.
REQ-032 SHALL implement the per-lane opcode evaluation and lane_out register in sub-module core_lane, instantiated L times by generate with lane index as a parameter.

Verification
REQ-033 SHALL cover: defaults with macro off, in_instr=32'h1000_0005 accepted at T -> out_valid at T+10, out_result=32'h0000_0044, out_overflow=0.
REQ-034 SHALL cover: in_instr=32'h3000_0003 -> out_result=32'h0000_006C, out_overflow=0.
REQ-035 SHALL cover: in_instr=32'h2000_0000 -> out_result=32'hFFFF_FFE4, out_overflow=1.
REQ-036 SHALL cover: out_ready held low 5 cycles in DONE with in_valid high -> outputs stable, in_ready=0, no accept; out_ready pulsed -> IDLE next cycle, accept the cycle after.
REQ-037 SHALL cover: rst during REDUCE -> next cycle in_ready=1, busy=0, out_valid=0; then 32'h1000_0005 -> 32'h0000_0044.
REQ-038 SHALL cover: PROB_LANE_EN defined, 32'h1000_0005 -> out_valid at T+11, out_result equal to 68 plus lfsr[0] from the bench's LFSR model, checked over 100 instructions.
